// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scan driver. It adds anti-ghost
// blanking, per-frame PWM brightness and a double-buffered load path, so the
// displayed frame only changes at a frame boundary.
//
// Optional feature: define SEVENSEG_HEXDECODE_EN to decode bits[3:0] of each
// cell as a hex digit onto segments A-G. Bit7 always passes through as DP.
// Without the macro, the cell bytes drive the segments raw.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   cellvalin   new frame data, cell k = bits [8k+7:8k] (bit0=A .. bit6=G, bit7=DP)
//   load_valid  producer offers cellvalin
//   load_ready  pending buffer empty; a transfer occurs on load_valid & load_ready
//   bright      brightness level, latched at each frame boundary
//   seg         segment drive (polarity set by SEG_ACTIVE_LOW)
//   dig         digit selects (polarity set by DIG_ACTIVE_LOW)
//   frame_done  one-cycle pulse following each frame boundary
module sevenseg_scan_ctrl #(
    parameter int unsigned NUMCELLS       = 4,
    parameter int unsigned BLANK_CYCLES   = 64,
    parameter int unsigned STEP_CYCLES    = 1024,
    parameter int unsigned BRIGHT_W       = 3,
    parameter int unsigned DIG_ACTIVE_LOW = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [8*NUMCELLS-1:0] cellvalin,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [7:0]            seg,
    output logic [NUMCELLS-1:0]   dig,
    output logic                  frame_done
);

    localparam int unsigned MAX_BRIGHT = (2 ** BRIGHT_W) - 1;
    localparam int unsigned SLOT       = BLANK_CYCLES + STEP_CYCLES * MAX_BRIGHT;
    localparam int unsigned CW         = $clog2(SLOT);
    localparam int unsigned KW         = $clog2(NUMCELLS);
    localparam int unsigned DW         = 8 * NUMCELLS;

    localparam logic [CW-1:0]       C_LAST  = CW'(SLOT - 1);
    localparam logic [KW-1:0]       K_LAST  = KW'(NUMCELLS - 1);
    localparam logic [7:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUMCELLS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUMCELLS{1'b1}}
                                                                     : {NUMCELLS{1'b0}};

`ifdef SEVENSEG_HEXDECODE_EN
    // Hex nibble to segments gfedcba
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction
`endif

    logic [CW-1:0]       c,        c_nxt;
    logic [KW-1:0]       k,        k_nxt;
    logic [DW-1:0]       display,  display_nxt;
    logic [DW-1:0]       pending,  pending_nxt;
    logic                pending_full, full_nxt;
    logic [BRIGHT_W-1:0] bright_l, bright_nxt;
    logic [7:0]          seg_nxt;
    logic [NUMCELLS-1:0] dig_nxt;
    logic                fd_nxt;

    logic                slot_end;
    logic                boundary;
    logic                handshake;
    logic                active;
    logic [31:0]         c_ext;
    logic [31:0]         on_len;
    logic [7:0]          cur_byte;
    logic [7:0]          seg_val;
    logic [NUMCELLS-1:0] dig_on;

    assign load_ready = ~pending_full;

`ifdef SEVENSEG_HEXDECODE_EN
    logic unused_hi;
    assign unused_hi = ^cur_byte[6:4];
`endif

    // Next-state: scan counters, buffer handshake and registered pin values
    always_comb begin
        c_nxt       = c;
        k_nxt       = k;
        display_nxt = display;
        pending_nxt = pending;
        full_nxt    = pending_full;
        bright_nxt  = bright_l;
        cur_byte    = 8'h00;

        slot_end  = (c == C_LAST);
        boundary  = slot_end && (k == K_LAST);
        handshake = load_valid && !pending_full;

        c_nxt = slot_end ? '0 : c + CW'(1);
        if (slot_end) begin
            k_nxt = (k == K_LAST) ? '0 : k + KW'(1);
        end

        // Commit looks at the pre-edge pending_full, so a handshake landing on
        // the boundary cycle waits for the following boundary.
        if (boundary) begin
            bright_nxt = bright;
            if (pending_full) begin
                display_nxt = pending;
                full_nxt    = 1'b0;
            end
        end
        if (handshake) begin
            pending_nxt = cellvalin;
            full_nxt    = 1'b1;
        end

        for (int i = 0; i < NUMCELLS; i++) begin
            if (k == KW'(i)) begin
                cur_byte = display[8*i +: 8];
            end
        end

        // Digit lit after the blanking gap for bright_l steps of STEP_CYCLES
        c_ext  = 32'(c);
        on_len = 32'(bright_l) * 32'(STEP_CYCLES);
        active = (c_ext >= 32'(BLANK_CYCLES)) && ((c_ext - 32'(BLANK_CYCLES)) < on_len);

`ifdef SEVENSEG_HEXDECODE_EN
        seg_val = {cur_byte[7], hex_to_seg(cur_byte[3:0])};
`else
        seg_val = cur_byte;
`endif
        dig_on  = NUMCELLS'(1) << k;

        seg_nxt = (active ? seg_val : 8'h00) ^ SEG_OFF;
        dig_nxt = (active ? dig_on : '0) ^ DIG_OFF;
        fd_nxt  = boundary;
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            c            <= '0;
            k            <= '0;
            display      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            bright_l     <= '0;
            seg          <= SEG_OFF;
            dig          <= DIG_OFF;
            frame_done   <= 1'b0;
        end else begin
            c            <= c_nxt;
            k            <= k_nxt;
            display      <= display_nxt;
            pending      <= pending_nxt;
            pending_full <= full_nxt;
            bright_l     <= bright_nxt;
            seg          <= seg_nxt;
            dig          <= dig_nxt;
            frame_done   <= fd_nxt;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl with NUMCELLS=4, BLANK=2, STEP=3, BRIGHT_W=2
// (slot 11 clocks, frame 44 clocks). A cycle-count reference model pushes the
// expected pin values at each rising edge; they are popped and compared on the
// following falling edge.
module tb_sevenseg_scan_ctrl;

    localparam int unsigned NC    = 4;
    localparam int unsigned BL    = 2;
    localparam int unsigned ST    = 3;
    localparam int unsigned BW    = 2;
    localparam int unsigned SLOT  = 11;
    localparam int unsigned FRAME = 44;

    logic          clock;
    logic          reset_n;
    logic [31:0]   cellvalin;
    logic          load_valid;
    logic          load_ready;
    logic [BW-1:0] bright;
    logic [7:0]    seg;
    logic [NC-1:0] dig;
    logic          frame_done;

    sevenseg_scan_ctrl #(
        .NUMCELLS      (NC),
        .BLANK_CYCLES  (BL),
        .STEP_CYCLES   (ST),
        .BRIGHT_W      (BW),
        .DIG_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(0)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cellvalin (cellvalin),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .bright    (bright),
        .seg       (seg),
        .dig       (dig),
        .frame_done(frame_done)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fd;
        logic       lr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef SEVENSEG_HEXDECODE_EN
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model state
    int          m_cyc;
    logic [31:0] m_disp;
    logic [31:0] m_pend;
    logic        m_full;
    logic [1:0]  m_bl;
    int          m_pos, m_k, m_c;
    logic        m_act;
    logic        m_old_full;
    logic [7:0]  m_b, m_sv;
    exp_t        m_e;
    exp_t        c_e;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cyc  = 0;
            m_disp = '0;
            m_pend = '0;
            m_full = 1'b0;
            m_bl   = '0;
            sb_q.delete();
        end else begin
            m_pos = m_cyc % FRAME;
            m_k   = m_pos / SLOT;
            m_c   = m_pos % SLOT;
            m_act = (m_c >= BL) && ((m_c - BL) < int'(m_bl) * ST);
            m_b   = m_disp[8*m_k +: 8];
`ifdef SEVENSEG_HEXDECODE_EN
            m_sv  = {m_b[7], hex_tbl[m_b[3:0]]};
`else
            m_sv  = m_b;
`endif
            m_e.seg = m_act ? m_sv : 8'h00;
            m_e.dig = m_act ? ~(4'b0001 << m_k) : 4'hF;
            m_e.fd  = (m_pos == FRAME - 1);

            m_old_full = m_full;
            if (m_pos == FRAME - 1) begin
                m_bl = bright;
                if (m_old_full) begin
                    m_disp = m_pend;
                    m_full = 1'b0;
                end
            end
            if (load_valid && !m_old_full) begin
                m_pend = cellvalin;
                m_full = 1'b1;
            end
            m_e.lr = ~m_full;
            sb_q.push_back(m_e);
            m_cyc++;
        end
    end

    always @(negedge clock) begin
        if (reset_n && sb_q.size() > 0) begin
            c_e = sb_q.pop_front();
            check("seg", 32'(seg), 32'(c_e.seg));
            check("dig", 32'(dig), 32'(c_e.dig));
            check("frame_done", 32'(frame_done), 32'(c_e.fd));
            check("load_ready", 32'(load_ready), 32'(c_e.lr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Advance to the falling edge before the rising edge at frame position p
    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((m_cyc % FRAME) == p) return;
            @(negedge clock);
        end
        check("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h00);
        check({tag, "_dig"}, 32'(dig), 32'hF);
        check({tag, "_ready"}, 32'(load_ready), 32'd1);
        check({tag, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b1;
        cellvalin  = 32'hDEADBEEF;
        bright     = 2'd3;

        // Reset held with an offered load: nothing captured, pins inactive
        tick(3);
        #1 check_idle("rst_hold");
        load_valid = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        tick(FRAME + 6);

        // Load a frame, shown from the next boundary at full brightness
        wait_pos(10);
        cellvalin  = 32'h3F065B4F;
        load_valid = 1'b1;
        bright     = 2'd3;
        tick(1);
        load_valid = 1'b0;
        cellvalin  = $urandom;
        tick(2 * FRAME);

        // Brightness change mid-frame applies only at the next boundary
        bright = 2'd1;
        wait_pos(0);
        tick(20);
        bright = 2'd2;
        tick(FRAME + 30);

        // Handshake exactly on the boundary cycle commits one frame later
        wait_pos(FRAME - 1);
        cellvalin  = 32'h11111111;
        load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(2 * FRAME + 5);

        // Back-pressure: valid held with data changing every cycle
        bright     = 2'd3;
        load_valid = 1'b1;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            cellvalin = $urandom;
            tick(1);
        end
        load_valid = 1'b0;
        tick(FRAME + 5);

        // Cell bytes with DP and high-nibble bits set
        wait_pos(20);
        cellvalin  = 32'h8A7C12F0;
        load_valid = 1'b1;
        tick(1);
        load_valid = 1'b0;
        tick(2 * FRAME);

        // Asynchronous reset between clock edges during a lit window
        wait_pos(5);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_idle("async_rst");
        tick(2);
        reset_n = 1'b1;
        tick(FRAME + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment scan driver. It is the successor to the fixed 4-cell scanner, generalised in cell count, scan timing, output polarity and brightness. It adds anti-ghost blanking, PWM brightness, and a double-buffered load handshake so frames never tear. It sits between the display-data producer and the segment/digit pins.

Parameters:
NUMCELLS, 4, number of digits scanned (>=2)
BLANK_CYCLES, 64, clocks per slot with all digits off before the digit turns on (>=1)
STEP_CYCLES, 1024, clocks per brightness step (>=1)
BRIGHT_W, 3, brightness input width
DIG_ACTIVE_LOW, 1, 1 = digit select asserted low
SEG_ACTIVE_LOW, 0, 1 = segment lit when low

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
cellvalin  in  8*NUMCELLS  cell k = bits [8k+7:8k]; bit0=A .. bit6=G, bit7=DP
load_valid  in  1  producer offers cellvalin
load_ready  out  1  pending buffer empty; transfer when load_valid & load_ready
bright  in  BRIGHT_W  brightness level; 0 = dark, 2^BRIGHT_W-1 = maximum
seg  out  8  segment drive, polarity per SEG_ACTIVE_LOW
dig  out  NUMCELLS  digit selects, polarity per DIG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Slot length: SLOT = BLANK_CYCLES + STEP_CYCLES*(2^BRIGHT_W-1) clocks. Frame = NUMCELLS*SLOT.
- Slot counter c runs 0..SLOT-1. Cell index k runs 0..NUMCELLS-1 and increments when c wraps. k wraps from NUMCELLS-1 to 0; that last cycle is the frame boundary.
- Slot k drives display byte k onto seg and asserts only dig[k].
- Active window:
  - dig[k] asserted iff c >= BLANK_CYCLES and (c-BLANK_CYCLES) < bright_l*STEP_CYCLES.
  - bright_l is the brightness latched at the frame boundary.
- seg equals the byte value during the active window and is all-inactive otherwise. At most one digit is ever asserted.
- seg, dig and frame_done are registered. They reflect the (c,k) state of the previous cycle, which gives 1-cycle latency.
- Buffers: display (shown) and pending, each 8*NUMCELLS.
- Load handshake:
  - load_ready = ~pending_full.
  - On handshake: pending <= cellvalin, pending_full <= 1.
  - cellvalin is ignored when no handshake occurs.
- Frame boundary:
  - If pending_full: display <= pending, pending_full <= 0, so load_ready is high the next cycle.
  - bright_l <= bright.
  - frame_done = 1 for one cycle.
- Simultaneous handshake and boundary with pending empty: the data enters pending and commits at the NEXT boundary, never the current one.
- bright changes mid-frame have no effect until the next boundary.
- Reset (asynchronous, any time):
  - c=0, k=0; display, pending and bright_l = 0; pending_full=0.
  - load_ready=1, frame_done=0.
  - seg all-inactive, dig all-inactive.
- After reset release the first frame shows blank (bright_l=0). Scanning restarts at cell 0.

Optional Feature:
SEVENSEG_HEXDECODE_EN
- Defined: each cell's bits[3:0] are a hex nibble, decoded to segments A-G (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - bit7 passes through as DP; bits[6:4] are ignored.
  - Decoding is applied at display readout, with the same latency.
- Undefined: bytes drive segments raw.

Test Plan:
All scenarios use NUMCELLS=4, BLANK_CYCLES=2, STEP_CYCLES=3, BRIGHT_W=2 (SLOT=11, frame=44).
- Reset: hold reset_n=0 with load_valid=1 -> seg=00, dig=F, load_ready=1, frame_done=0. Release -> first frame dig stays F, and frame_done pulses once after 44 clocks.
- Load: cellvalin=0x3F065B4F, load_valid one cycle, bright=3 -> load_ready low until the boundary. Next frame slot0: dig=E, seg=4F for 9 clocks after 2 blank clocks. Slots 1..3 show 5B, 06, 3F on dig=D, B, 7.
- Brightness: bright=1, then change to 2 mid-frame -> current frame keeps 3-clock on-time per slot; next frame uses 6.
- Boundary collision: handshake on the exact boundary cycle with new data 0x11111111 -> current frame still shows the old data; new data appears one frame later. load_ready stays low through that frame.
- Back-pressure: load_valid held high two frames with changing data -> exactly one transfer per frame, and the value captured is the one present at load_ready=1.
- With SEVENSEG_HEXDECODE_EN, cell byte 0x8A -> seg=F7 (77 plus DP). Mid-frame reset_n pulse -> outputs go inactive immediately, asynchronously.
